mult_div_unit: RTL
==================

# mult_div_unit

Iterative 32-bit multiply/divide engine behind the ALU's `mult_start`/`div_start`/`mult_div_done` handshake. It supplies the 64-bit product or the quotient/remainder pair that the datapath captures into its ALU output registers and then into hi/lo. The multiplier is radix-2 shift-add and the divider is restoring. Signed operation uses magnitude conversion with a final sign-fix cycle.

## Interface
Parameters:
- `WIDTH`, default 32: operand and per-half result width.
- `CNT_W`, default 6: iteration counter width; must hold `WIDTH`.

Ports:
- `CLK` input 1: clock; all logic is on the rising edge.
- `RST` input 1: reset. One clock; reset is synchronous and active-low.
- `mult_start` input 1: start-multiply request, sampled in IDLE.
- `div_start` input 1: start-divide request, sampled in IDLE.
- `is_signed` input 1: 1 = two's-complement operands (MULT/DIV); 0 = unsigned (MULTU/DIVU). Sampled with start.
- `Operand1` input WIDTH: multiplicand or dividend (rs), sampled with start.
- `Operand2` input WIDTH: multiplier or divisor (rt), sampled with start.
- `result_hi` output WIDTH: product[2W-1:W], or the remainder.
- `result_lo` output WIDTH: product[W-1:0], or the quotient.
- `mult_div_done` output 1: one-cycle pulse; results are valid in that cycle.
- `busy` output 1: high in BUSY and FIX.
- `div_by_zero` output 1: valid with `mult_div_done`; high if a divide had divisor 0.

## Operation
- States: IDLE, BUSY, FIX, DONE.
- IDLE → BUSY when `mult_start | div_start`.
  - If both are high, multiply wins.
  - On entry: latch the op, `is_signed`, the operand magnitudes (negate if signed and MSB=1), and the result sign flags. Clear the accumulator. Set the counter to 0.
- BUSY: one iteration per cycle; the counter increments. Leave BUSY to FIX after iteration WIDTH-1 (WIDTH iterations total).
  - Multiply: if multiplier LSB is 1, add the multiplicand to the upper half of the 2W accumulator, keeping the carry-out. Then shift the {carry, acc} right by 1.
  - Divide (restoring): shift the {rem, quo} pair left by 1. Trial-subtract the divisor from rem using W+1 bits. If non-negative, keep the difference and set quo LSB=1.
- FIX: apply the sign and register the outputs.
  - Multiply: negate the 2W product if the operand signs differed (signed only).
  - Divide: negate the quotient if the signs differed; the remainder takes the sign of the dividend.
  - FIX → DONE.
- DONE: `mult_div_done`=1 for exactly one cycle, then go to IDLE.
- Outputs hold their last values until the next FIX. New results never appear outside FIX→DONE.
- Divide by zero: runs the full latency. Result is quotient = all ones and remainder = dividend (original, unsigned-view bits). `div_by_zero`=1 in DONE.
- Signed 0x80000000 / −1: quotient = 0x80000000, remainder = 0. No flag.
- Start asserted outside IDLE is ignored and not queued. Start high in the DONE cycle is also ignored; it is accepted in the following IDLE cycle if still high.
- Operand changes after the start cycle have no effect.

## Timing
- Reset (RST=0 at an edge), from any state, including mid-operation:
  - State goes to IDLE; `result_hi`, `result_lo`, `mult_div_done`, `busy`, `div_by_zero` = 0.
  - The in-flight operation is discarded; no done pulse follows.
- Start high in cycle 0 (IDLE):
  - `busy` is high in cycles 1..WIDTH+1.
  - `mult_div_done` is high in cycle WIDTH+2 (cycle 34 for WIDTH=32), with results valid that cycle.
  - Cycle WIDTH+3 is IDLE, so a new start there is accepted.
- Sustained throughput: one operation per WIDTH+3 cycles.
- `busy` and `mult_div_done` are never high in the same cycle.

## Structure
- Shared package `mult_div_pkg`:
  - state enum `md_state_t` {IDLE, BUSY, FIX, DONE};
  - op encoding `MD_OP_MULT`=1'b0, `MD_OP_DIV`=1'b1;
  - localparam `MD_LATENCY` = WIDTH+2.
- Single module with no sub-modules. The shared 2W accumulator, the W+1 adder/subtractor, the counter and the sign-fix negators are all inline.

## Test plan
- Unsigned mult, 7 × 6: done in cycle 34 exactly, hi=0x00000000, lo=0x0000002A; `busy` high cycles 1–33.
- Signed mult −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Unsigned mult 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed div −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. Unsigned 100 / 7 → lo=14, hi=2.
- Divide by zero, 100 / 0 → lo=0xFFFFFFFF, hi=100, `div_by_zero`=1 for the done cycle only, latency still 34.
- `mult_start` and `div_start` together with 9, 3 → multiply result lo=27. A `div_start` pulse at cycle 5 is ignored (no second done). A start held through cycle 35 is accepted in cycle 35, with done in cycle 69.
- RST=0 at cycle 10 mid-divide: from cycle 11, all outputs are 0 and no done appears. After release, a new 2 × 2 completes with lo=4 in the normal 34 cycles from its start.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide engine.
package mult_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    localparam int MD_WIDTH   = 32;
    localparam int MD_LATENCY = MD_WIDTH + 2;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine: radix-2 shift-add multiplier and restoring
// divider sharing one 2W accumulator and one W+1 adder/subtractor. Signed
// operands are converted to magnitudes on entry and the sign is restored in FIX.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             mult_div_done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]     ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0]   ONE_2W   = (2*WIDTH)'(1);

    // Two's-complement magnitude when the value is signed and negative.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] m;
        if (sgn && v[WIDTH-1]) begin
            m = ~v + ONE_W;
        end else begin
            m = v;
        end
        return m;
    endfunction

    md_state_t            state_r;
    logic                 op_r;
    logic                 neg_lo_r;      // negate product / quotient
    logic                 neg_hi_r;      // negate remainder
    logic                 dbz_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [2*WIDTH-1:0]   acc_r;         // mult: {product_hi, multiplier/product_lo}; div: {rem, quo}
    logic [WIDTH-1:0]     opb_r;         // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]     result_hi_r;
    logic [WIDTH-1:0]     result_lo_r;
    logic                 done_r;
    logic                 busy_r;
    logic                 div_by_zero_r;

    logic [WIDTH:0]       alu_a_s;
    logic [WIDTH:0]       alu_b_s;
    logic                 alu_cin_s;
    logic [WIDTH:0]       alu_sum_s;
    logic [2*WIDTH-1:0]   iter_s;
    logic [2*WIDTH-1:0]   prod_neg_s;
    logic [WIDTH-1:0]     rem_neg_s;
    logic [WIDTH-1:0]     quo_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;
    logic [2*WIDTH-1:0]   prod_fix_s;

    // One iteration step: shared W+1 adder (mult) / trial subtractor (div).
    always_comb begin
        alu_a_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        alu_b_s   = {1'b0, opb_r};
        alu_cin_s = 1'b0;
        if (op_r == MD_OP_DIV) begin
            alu_a_s   = acc_r[2*WIDTH-1:WIDTH-1];
            alu_b_s   = ~{1'b0, opb_r};
            alu_cin_s = 1'b1;
        end else begin
            alu_a_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
            alu_b_s   = {1'b0, opb_r};
            alu_cin_s = 1'b0;
        end
        alu_sum_s = alu_a_s + alu_b_s + {{WIDTH{1'b0}}, alu_cin_s};

        iter_s = acc_r;
        if (op_r == MD_OP_DIV) begin
            if (!alu_sum_s[WIDTH]) begin
                iter_s = {alu_sum_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                iter_s = {acc_r[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc_r[0]) begin
                iter_s = {alu_sum_s, acc_r[WIDTH-1:1]};
            end else begin
                iter_s = {1'b0, acc_r[2*WIDTH-1:1]};
            end
        end
    end

    // Sign restoration; a zero divisor forces the all-ones quotient.
    always_comb begin
        prod_neg_s = ~acc_r + ONE_2W;
        rem_neg_s  = ~acc_r[2*WIDTH-1:WIDTH] + ONE_W;
        prod_fix_s = neg_lo_r ? prod_neg_s : acc_r;
        rem_fix_s  = neg_hi_r ? rem_neg_s : acc_r[2*WIDTH-1:WIDTH];
        if (dbz_r) begin
            quo_fix_s = {WIDTH{1'b1}};
        end else begin
            quo_fix_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Control FSM with operand capture, iteration and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r       <= IDLE;
            op_r          <= MD_OP_MULT;
            neg_lo_r      <= 1'b0;
            neg_hi_r      <= 1'b0;
            dbz_r         <= 1'b0;
            cnt_r         <= {CNT_W{1'b0}};
            acc_r         <= {(2*WIDTH){1'b0}};
            opb_r         <= {WIDTH{1'b0}};
            result_hi_r   <= {WIDTH{1'b0}};
            result_lo_r   <= {WIDTH{1'b0}};
            done_r        <= 1'b0;
            busy_r        <= 1'b0;
            div_by_zero_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r        <= 1'b0;
                    div_by_zero_r <= 1'b0;
                    if (mult_start || div_start) begin
                        op_r     <= mult_start ? MD_OP_MULT : MD_OP_DIV;
                        neg_lo_r <= is_signed & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
                        neg_hi_r <= is_signed & Operand1[WIDTH-1] & ~mult_start;
                        dbz_r    <= ~mult_start & (Operand2 == {WIDTH{1'b0}});
                        cnt_r    <= {CNT_W{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= BUSY;
                        if (mult_start) begin
                            acc_r <= {{WIDTH{1'b0}}, magnitude(Operand2, is_signed)};
                            opb_r <= magnitude(Operand1, is_signed);
                        end else begin
                            acc_r <= {{WIDTH{1'b0}}, magnitude(Operand1, is_signed)};
                            opb_r <= magnitude(Operand2, is_signed);
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    acc_r <= iter_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                FIX: begin
                    if (op_r == MD_OP_MULT) begin
                        result_hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
                        result_lo_r <= prod_fix_s[WIDTH-1:0];
                    end else begin
                        result_hi_r <= rem_fix_s;
                        result_lo_r <= quo_fix_s;
                    end
                    div_by_zero_r <= dbz_r;
                    done_r        <= 1'b1;
                    busy_r        <= 1'b0;
                    state_r       <= DONE;
                end
                DONE: begin
                    done_r        <= 1'b0;
                    div_by_zero_r <= 1'b0;
                    state_r       <= IDLE;
                end
                default: begin
                    done_r        <= 1'b0;
                    busy_r        <= 1'b0;
                    div_by_zero_r <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

    assign result_hi     = result_hi_r;
    assign result_lo     = result_lo_r;
    assign mult_div_done = done_r;
    assign busy          = busy_r;
    assign div_by_zero   = div_by_zero_r;

endmodule
